// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, frame constants and baud divisor helper (PARITY state only with UART_TX_PARITY_EN)
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;
  function automatic int baud_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter 0..BAUD_CNT-1; ports clk, rst_n (async low), clr (sync clear), tick (high on the wrap cycle)
module uart_baud_gen #(
  parameter int BAUD_CNT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = BAUD_CNT > 1 ? $clog2(BAUD_CNT) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(BAUD_CNT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (even parity bit with UART_TX_PARITY_EN); ports clk, rst_n (async low), tx_data, tx_start in; tx, tx_busy, tx_done (registered) out
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BAUD_CNT = baud_cnt(CLK_FREQ, BAUD_RATE);
  uart_tx_state_t state, state_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic [2:0] idx, idx_d;
  logic tick, accept, last, tx_d, busy_d, done_d;
  uart_baud_gen #(.BAUD_CNT(BAUD_CNT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .tick (tick)
  );
  assign accept = state == IDLE && tx_start;
  assign last = idx == 3'(UART_DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (accept) par <= ^tx_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      tx <= UART_IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_d;
      shift <= shift_d;
      idx <= idx_d;
      tx <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = tx_start ? START : IDLE;
      START:   state_d = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:    state_d = (tick && last) ? PARITY : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
`else
      DATA:    state_d = (tick && last) ? STOP : DATA;
`endif
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // outputs are computed from the next state so the registered tx lines up with the bit slot
  always_comb begin
    shift_d = accept ? tx_data : (state == DATA && tick) ? shift >> 1 : shift;
    idx_d = state != DATA ? 3'd0 : tick ? idx + 3'd1 : idx;
    busy_d = state_d != IDLE;
    done_d = state == STOP && tick;
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par : UART_IDLE_LEVEL;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : UART_IDLE_LEVEL;
`endif
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at BAUD_CNT=10
module tb_uart_tx;
  import uart_pkg::*;
  localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx, tx_busy, tx_done;
  int n_cmp = 0;
  int n_bad = 0;
  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic frame_bit(input logic [7:0] d, input int s);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^d, d, 1'b0};
`else
    f = {2'b11, d, 1'b0};
`endif
    return f[s];
  endfunction
  task automatic frame(input string tag, input logic [7:0] d, input bit hold, input int inj);
    if (!hold) tx_start = 1'b0;
    for (int k = 0; k < NB * BC; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s tx k=%0d", tag, k), tx, frame_bit(d, k / BC));
      check($sformatf("%s busy k=%0d", tag, k), tx_busy, 1);
      check($sformatf("%s done k=%0d", tag, k), tx_done, 0);
      if (inj >= 0 && k == inj) begin
        tx_start = 1'b1;
        tx_data = 8'h3C;
      end
      if (inj >= 0 && k == inj + 1) tx_start = 1'b0;
    end
    @(negedge clk);
    check({tag, " done pulse"}, tx_done, 1);
    check({tag, " busy end"}, tx_busy, 0);
    check({tag, " idle tx"}, tx, 1);
  endtask
  task automatic send(input string tag, input logic [7:0] d, input int inj);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    frame(tag, d, 1'b0, inj);
  endtask
  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s tx i=%0d", tag, i), tx, 1);
      check($sformatf("%s busy i=%0d", tag, i), tx_busy, 0);
      check($sformatf("%s done i=%0d", tag, i), tx_done, 0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", tx_busy, 0);
    check("reset done", tx_done, 0);
    check("baud_cnt default", baud_cnt(100_000_000, 9600), 10416);
    rst_n = 1'b1;
    idle_check("post reset", 3);
    send("a5", 8'hA5, -1);
    idle_check("after a5", 2);
    tx_data = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    frame("b2b 00", 8'h00, 1'b1, -1);
    @(negedge clk);
    frame("b2b ff", 8'hFF, 1'b0, -1);
    idle_check("after b2b", 2 * BC);
    send("busy 81", 8'h81, 40);
    idle_check("after busy", 2 * BC);
    tx_data = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (34) @(negedge clk);
    check("pre-reset tx", tx, 0);
    check("pre-reset busy", tx_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset busy", tx_busy, 0);
    check("async reset done", tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("after reset", 2);
    send("55", 8'h55, -1);
    idle_check("after 55", 2);
    send("07", 8'h07, -1);
    idle_check("after 07", 2);
    send("03", 8'h03, -1);
    idle_check("after 03", 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one byte per request into an 8N1 frame (optional even parity) on the `tx` line. It is the transmit counterpart of the team's UART receiver, runs on the same system clock and baud parameters, and is driven by a byte producer through a start/busy handshake. The frame's LSB is sent first, and the line idles high.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate in bits per second.

Ports:
- `clk`, input, 1 bit: system clock; all logic is on its rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `tx_data`, input, 8 bits: byte to send; sampled only when a start is accepted.
- `tx_start`, input, 1 bit: transmit request; a one-cycle pulse or a held level.
- `tx`, output, 1 bit: serial line; idles at 1.
- `tx_busy`, output, 1 bit: high while a frame is in flight.
- `tx_done`, output, 1 bit: one-cycle pulse when the stop bit completes.

## Operation
- Derived constant: `BAUD_CNT = CLK_FREQ / BAUD_RATE`, using integer division with truncation. This gives 10416 at the defaults.
- Baud counter width is `$clog2(BAUD_CNT)` bits. The counter runs 0..`BAUD_CNT-1`, wraps to 0 and raises a bit-end tick on the wrap cycle.
- State machine states are IDLE, START, DATA, PARITY (present only when configured), and STOP.
- IDLE:
  - `tx`=1 and `tx_busy`=0.
  - If `tx_start`=1, latch `tx_data` into the shift register, clear the baud counter and go to START.
- START: `tx`=0 for `BAUD_CNT` cycles. On the tick, go to DATA with bit index 0.
- DATA:
  - `tx` = `shift[0]` for `BAUD_CNT` cycles.
  - On each tick, shift right and increment the bit index.
  - After the tick for index 7, go to PARITY if enabled, otherwise to STOP.
- PARITY: `tx` = XOR of the latched byte (even parity) for `BAUD_CNT` cycles, then go to STOP.
- STOP: `tx`=1 for `BAUD_CNT` cycles. On the tick, go to IDLE and pulse `tx_done`.
- A `tx_start` outside IDLE is ignored, not queued. Changes to `tx_data` after acceptance do not affect the frame in flight.
- Holding `tx_start` high continuously sends back-to-back frames, each sampling `tx_data` at its own acceptance.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0, shift register 0. Reset asserted mid-frame forces these values immediately (asynchronously), and the partial frame is abandoned.

## Timing
- All outputs are registered.
- The acceptance edge is the clock edge where IDLE and `tx_start`=1. On the following cycle, `tx` is 0 and `tx_busy` is 1.
- The start bit occupies exactly `BAUD_CNT` cycles, as does every bit after it.
- Frame length is `10*BAUD_CNT` cycles, or `11*BAUD_CNT` with parity.
- In the final cycle of the frame (`BAUD_CNT` cycles after the stop bit began), `tx_done`=1 and `tx_busy` falls to 0 on the same edge. `tx_done` lasts exactly one cycle.
- Minimum gap between frames is zero extra idle bit time:
  - `tx_start` high in the first IDLE cycle is accepted.
  - The next start bit then begins 1 cycle after the stop bit ends, so there is 1 idle-high cycle between frames.
- `tx_done` never coincides with acceptance; acceptance can occur at the earliest on the cycle after `tx_done`.

## Configuration
- The macro `UART_TX_PARITY_EN` controls the parity bit.
- Defined: the PARITY state is compiled in and frames are start + 8 data + even-parity + stop, i.e. 11 bits.
- Undefined: no PARITY state or parity logic exists and frames are 8N1, i.e. 10 bits.
- The setting must match the receiver's configuration.

## Structure
- Shared package `uart_pkg` holds:
  - the state enumeration `uart_tx_state_t`;
  - the function `baud_cnt(clk_freq, baud_rate)`, shared with the receiver;
  - the constants `UART_DATA_BITS` = 8 and `UART_IDLE_LEVEL` = 1.
- Sub-module `uart_baud_gen` contains the baud counter. Its inputs are `clk`, `rst_n` and a synchronous clear; it outputs the bit-end tick and is parameterized by `BAUD_CNT`. The receiver can reuse it.

## Test plan
Unless stated otherwise, tests use `CLK_FREQ`=1_000_000 and `BAUD_RATE`=100_000, so `BAUD_CNT`=10.
- **Single byte:** pulse `tx_start` with `tx_data`=8'hA5.
  - `tx` sequence per 10-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` is high for 100 cycles and `tx_done` pulses once at cycle 100.
- **Back-to-back:** hold `tx_start`=1 with 8'h00, then 8'hFF.
  - Two frames are sent with exactly 1 idle-high cycle between them and two `tx_done` pulses.
  - A loopback into the UART receiver yields 8'h00 then 8'hFF.
- **Start while busy:** pulse `tx_start` with 8'h3C at cycle 40 of a frame carrying 8'h81.
  - The request is ignored: only 8'h81 is sent and there is one `tx_done`.
- **Reset mid-frame:** drop `rst_n` at cycle 35.
  - `tx`=1, `tx_busy`=0 and `tx_done`=0 before the next clock edge.
  - After release, a new send of 8'h55 produces a correct frame.
- **Parity (with `UART_TX_PARITY_EN`):** send 8'h07.
  - Parity slot = 1 and the frame is 110 cycles.
  - Sending 8'h03 gives parity slot = 0.
- **Default parameters:** send 8'h5A.
  - Each bit lasts 10416 cycles and the frame lasts 104160 cycles.
